// File: rtl/wb_burst_sram_responder.sv
// wb_burst_sram_responder: Wishbone B3 registered-feedback SRAM slave with linear/wrapping bursts
module wb_burst_sram_responder #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] wb_dat_o
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [MEM_AW-1:0] w, w_nx, w_adv;
    logic ack_nx, err_nx, accept, first_ok, lin_top;
    logic [31:0] mem [2**MEM_AW];

    assign wb_rty_o = 1'b0;
    assign accept   = wb_ack_o & wb_cyc_i & wb_stb_i;
    assign first_ok = (wb_adr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]) && (wb_adr_i[1:0] == 2'b00);
    assign lin_top  = (wb_bte_i == 2'b00) && (&w);

    // next burst word: linear, or wrap inside an aligned 4/8/16-word block
    always_comb begin
        w_adv = w;
        case (wb_bte_i)
            2'b00:   w_adv      = w + MEM_AW'(1);
            2'b01:   w_adv[1:0] = w[1:0] + 2'd1;
            2'b10:   w_adv[2:0] = w[2:0] + 3'd1;
            default: w_adv[3:0] = w[3:0] + 4'd1;
        endcase
    end

    // next state and next termination; an ack/err cycle is never mistaken for a new request
    always_comb begin
        state_nx = state;
        w_nx     = w;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        if (!wb_cyc_i) begin
            state_nx = IDLE;
        end else if (state == IDLE) begin
            if (wb_stb_i && !wb_ack_o && !wb_err_o) begin
                if (first_ok) begin
                    w_nx     = wb_adr_i[MEM_AW+1:2];
                    ack_nx   = 1'b1;
                    state_nx = (wb_cti_i == 3'b010) ? BURST : IDLE;
                end else begin
                    err_nx = 1'b1;
                end
            end
        end else if (accept) begin
            if (wb_cti_i != 3'b010) begin
                state_nx = IDLE;
            end else if (lin_top) begin
                err_nx   = 1'b1;
                state_nx = IDLE;
            end else begin
                w_nx   = w_adv;
                ack_nx = 1'b1;
            end
        end else if (!wb_ack_o && wb_stb_i) begin
            ack_nx = 1'b1;
        end
    end

    // control registers and read-ahead data; data is zero whenever no ack is issued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            w        <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            state    <= state_nx;
            w        <= w_nx;
            wb_ack_o <= ack_nx;
            wb_err_o <= err_nx;
            wb_dat_o <= ack_nx ? mem[w_nx] : '0;
        end
    end

    // byte-masked write on accepted write beats; contents survive reset
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++)
            if (accept && wb_we_i && wb_sel_i[b]) mem[w][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
endmodule

// File: tb/tb_wb_burst_sram_responder.sv
// tb_wb_burst_sram_responder: vector table, directed burst corners and random bursts vs a transaction model
module tb_wb_burst_sram_responder;
    localparam int          AW    = 6;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [31:0] wb_dat_o;

    wb_burst_sram_responder #(.MEM_AW(AW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wdat [DEPTH];
    logic [3:0]  wsel [DEPTH];
    logic [31:0] rd_q [$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        ack;
        logic        err;
        logic        chk;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beat_word(input int s, input int k, input logic [1:0] bte);
        int m;
        m = (bte == 2'd0) ? 0 : (bte == 2'd1) ? 4 : (bte == 2'd2) ? 8 : 16;
        return (m == 0) ? s + k : (s - s % m) + (s + k) % m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sl);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sl[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return a >= BASE && a < BASE + 32'(4 * DEPTH) && a[1:0] == 2'b00;
    endfunction

    task automatic idle_bus();
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0;
        wb_dat_i = 0; wb_sel_i = 0; wb_cti_i = 0; wb_bte_i = 0;
    endtask

    task automatic drive(input logic [31:0] adr0, input int k, input int n, input logic [1:0] b,
                         input logic w_e, input logic s, input int s0);
        wb_cyc_i = 1; wb_stb_i = s; wb_we_i = w_e; wb_bte_i = b;
        wb_cti_i = (n == 1) ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010;
        wb_adr_i = (k == 0) ? adr0 : BASE + 32'(4 * beat_word(s0, k, b));
        wb_dat_i = wdat[k]; wb_sel_i = wsel[k];
    endtask

    // master for an n-beat transaction; the slave must answer in the cycle after every strobed
    // cycle until the last beat is taken, with err for a beat outside the window
    task automatic burst(input logic [31:0] adr0, input int n, input logic [1:0] bte, input logic we,
                         input int hold_k, input int hold_n, input int wait_pct);
        int k = 0, held = 0, steps = 0, s0, wd;
        bit leg, resp, prev_stb, ok0, go;
        ok0 = in_win(adr0);
        s0  = ok0 ? int'((adr0 - BASE) >> 2) : 0;
        rd_q.delete();
        drive(adr0, 0, n, bte, we, 1'b1, s0);
        prev_stb = 1;
        forever begin
            @(posedge clk_i); #1;
            steps++;
            if (steps > 400) begin
                check("burst_timeout", 32'(steps), 32'(0));
                break;
            end
            resp = prev_stb && k < n;
            wd   = beat_word(s0, k, bte);
            leg  = (k == 0) ? ok0 : (wd < DEPTH);
            check("ack", 32'(wb_ack_o), 32'(resp && leg));
            check("err", 32'(wb_err_o), 32'(resp && !leg));
            if (resp && !leg) begin
                check("err_dat", wb_dat_o, 32'h0);
                k = n;
                continue;
            end
            if (resp && !we) begin
                check("rd_dat", wb_dat_o, ref_mem[wd]);
                rd_q.push_back(wb_dat_o);
            end
            if (k >= n) begin
                wb_stb_i = 0; wb_cti_i = 0;
                break;
            end
            go = !(k == hold_k && held < hold_n) && ($urandom_range(99) >= 32'(wait_pct));
            if (k == hold_k && held < hold_n) held++;
            drive(adr0, k, n, bte, we, go, s0);
            if (resp && go) begin
                if (we) ref_mem[wd] = merge(ref_mem[wd], wdat[k], wsel[k]);
                k++;
            end
            prev_stb = go;
        end
    endtask

    task automatic classic(input logic w_e, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl,
                           output logic ak, output logic er, output logic [31:0] dt, output int lat);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = w_e; wb_adr_i = a;
        wb_dat_i = d; wb_sel_i = sl; wb_cti_i = 0; wb_bte_i = 0;
        ak = 0; er = 0; dt = 0; lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o || wb_err_o) begin
                ak = wb_ack_o; er = wb_err_o; dt = wb_dat_o; lat = i;
                break;
            end
        end
        if (ak && w_e) ref_mem[int'((a - BASE) >> 2)] = merge(ref_mem[int'((a - BASE) >> 2)], d, sl);
        @(posedge clk_i); #1;
        check("classic_idle_after", 32'({wb_ack_o, wb_err_o}), 32'(0));
        idle_bus();
    endtask

    // bus-level invariants checked every cycle
    logic cyc_q = 1'b0;
    always @(posedge clk_i) cyc_q <= wb_cyc_i;
    always @(negedge clk_i) if (rst_ni) begin
        check("ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'(0));
        check("resp_without_cyc", 32'((wb_ack_o | wb_err_o) & !cyc_q), 32'(0));
        check("rty", 32'(wb_rty_o), 32'(0));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic        ak, er;
        logic [31:0] dt, adr0;
        int          lat, n, r;
        logic [1:0]  bte;
        logic        we;
        logic [31:0] exp30 [6];

        tbl[0]  = '{1, BASE + 32'h10,  32'hDEAD_BEEF, 4'hF,    1, 0, 0, 32'h0};
        tbl[1]  = '{0, BASE + 32'h10,  32'h0,         4'hF,    1, 0, 1, 32'hDEAD_BEEF};
        tbl[2]  = '{1, BASE + 32'h10,  32'h0000_AB00, 4'b0010, 1, 0, 0, 32'h0};
        tbl[3]  = '{0, BASE + 32'h10,  32'h0,         4'h0,    1, 0, 1, 32'hDEAD_ABEF};
        tbl[4]  = '{0, BASE + 32'h100, 32'h0,         4'hF,    0, 1, 1, 32'h0};
        tbl[5]  = '{0, BASE - 32'h4,   32'h0,         4'hF,    0, 1, 1, 32'h0};
        tbl[6]  = '{1, BASE + 32'h12,  32'h1111_1111, 4'hF,    0, 1, 1, 32'h0};
        tbl[7]  = '{1, BASE + 32'hFC,  32'h1234_5678, 4'b1001, 1, 0, 0, 32'h0};
        tbl[8]  = '{0, BASE + 32'h10,  32'h0,         4'hF,    1, 0, 1, 32'hDEAD_ABEF};
        tbl[9]  = '{0, BASE + 32'hFC,  32'h0,         4'hF,    1, 0, 1, 32'h12DE_0078};
        tbl[10] = '{1, BASE + 32'h104, 32'h5555_5555, 4'hF,    0, 1, 1, 32'h0};

        idle_bus();
        #12;
        check("rst_ack", 32'(wb_ack_o), 32'(0));
        check("rst_err", 32'(wb_err_o), 32'(0));
        check("rst_dat", wb_dat_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1;

        for (int i = 0; i < DEPTH; i++) begin
            wdat[i] = (i >= 4 && i < 8) ? 32'(i) : 32'hC0DE_0000 + 32'(i);
            wsel[i] = 4'hF;
        end
        burst(BASE, DEPTH, 2'b00, 1'b1, -1, 0, 0);

        burst(BASE + 32'h18, 4, 2'b01, 1'b0, -1, 0, 0);
        check("wrap4_len", 32'(rd_q.size()), 32'(4));
        if (rd_q.size() == 4) begin
            check("wrap4_b0", rd_q[0], 32'h6);
            check("wrap4_b1", rd_q[1], 32'h7);
            check("wrap4_b2", rd_q[2], 32'h4);
            check("wrap4_b3", rd_q[3], 32'h5);
        end

        for (int i = 0; i < 11; i++) begin
            classic(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, ak, er, dt, lat);
            check($sformatf("vec%0d_ack", i), 32'(ak), 32'(tbl[i].ack));
            check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(1));
            if (tbl[i].chk) check($sformatf("vec%0d_dat", i), dt, tbl[i].rd);
        end

        for (int i = 0; i < 4; i++) wdat[i] = 32'h3000_0000 + 32'(i);
        burst(BASE + 32'h50, 4, 2'b00, 1'b1, 2, 2, 0);
        burst(BASE + 32'h4C, 6, 2'b00, 1'b0, -1, 0, 0);
        exp30 = '{32'hC0DE_0013, 32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003, 32'hC0DE_0018};
        check("wait_len", 32'(rd_q.size()), 32'(6));
        if (rd_q.size() == 6) for (int i = 0; i < 6; i++) check($sformatf("wait_word%0d", i), rd_q[i], exp30[i]);

        wdat[0] = 32'hAAAA_5555; wdat[1] = 32'hBBBB_6666;
        burst(BASE + 32'hFC, 2, 2'b00, 1'b1, -1, 0, 0);
        classic(1'b0, BASE + 32'hFC, 32'h0, 4'hF, ak, er, dt, lat);
        check("top_word", dt, 32'hAAAA_5555);
        classic(1'b0, BASE, 32'h0, 4'hF, ak, er, dt, lat);
        check("word0_intact", dt, 32'hC0DE_0000);

        for (int i = 0; i < 8; i++) begin
            wdat[i] = 32'hA000_0000 + 32'(i);
            wsel[i] = 4'hF;
        end
        drive(BASE + 32'h20, 0, 8, 2'b10, 1'b1, 1'b1, 8);
        @(posedge clk_i); #1;
        check("rst_burst_b1_ack", 32'(wb_ack_o), 32'(1));
        ref_mem[8] = wdat[0];
        @(posedge clk_i); #1;
        check("rst_burst_b2_ack", 32'(wb_ack_o), 32'(1));
        drive(BASE + 32'h20, 1, 8, 2'b10, 1'b1, 1'b1, 8);
        #2 rst_ni = 0;
        #1;
        check("async_rst_ack", 32'(wb_ack_o), 32'(0));
        check("async_rst_dat", wb_dat_o, 32'h0);
        for (int k = 2; k < 5; k++) begin
            @(posedge clk_i); #1;
            check("in_rst_ack", 32'(wb_ack_o), 32'(0));
            drive(BASE + 32'h20, k, 8, 2'b10, 1'b1, 1'b1, 8);
        end
        idle_bus();
        rst_ni = 1;
        @(posedge clk_i); #1;
        classic(1'b0, BASE + 32'h20, 32'h0, 4'hF, ak, er, dt, lat);
        check("post_rst_ack", 32'(ak), 32'(1));
        check("post_rst_lat", 32'(lat), 32'(1));
        check("post_rst_b1", dt, 32'hA000_0000);
        classic(1'b0, BASE + 32'h24, 32'h0, 4'hF, ak, er, dt, lat);
        check("post_rst_b2", dt, 32'hC0DE_0009);
        burst(BASE + 32'h20, 8, 2'b10, 1'b0, -1, 0, 0);

        for (int t = 0; t < 80; t++) begin
            n   = int'($urandom_range(1, 8));
            bte = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            if (r == 0) begin
                case ($urandom_range(0, 2))
                    0: adr0 = BASE + 32'h100 + 32'(4 * $urandom_range(0, 8));
                    1: adr0 = BASE - 32'(4 * $urandom_range(1, 4));
                    default: adr0 = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                endcase
            end else if (r == 1) begin
                adr0 = BASE + 32'(4 * (DEPTH - int'($urandom_range(1, 4))));
            end else begin
                adr0 = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            end
            for (int k = 0; k < n; k++) begin
                wdat[k] = $urandom;
                wsel[k] = 4'($urandom_range(0, 15));
            end
            burst(adr0, n, bte, we, -1, 0, 25);
            if ($urandom_range(0, 1) == 1) begin
                idle_bus();
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk_i); #1;
                end
            end
        end
        idle_bus();
        @(posedge clk_i); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
